// File: rtl/line_setup_if.sv
// Clipper-side segment handshake and line-FIFO write port of line_setup.
interface line_setup_if;
    logic        in_valid;
    logic        in_ready;
    logic [9:0]  in_x0, in_y0, in_x1, in_y1;
    logic [2:0]  in_color;
    logic        in_draw;
    logic        fifo_full;
    logic        fifo_wr_en;
    logic [68:0] fifo_din;

    modport master (output in_valid, in_x0, in_y0, in_x1, in_y1, in_color, in_draw, fifo_full,
                    input  in_ready, fifo_wr_en, fifo_din);
    modport slave  (input  in_valid, in_x0, in_y0, in_x1, in_y1, in_color, in_draw, fifo_full,
                    output in_ready, fifo_wr_en, fifo_din);
endinterface

// File: rtl/line_setup.sv
// Line setup: captures a clipped segment, computes deltas/octant/range check, pushes a
// 69-bit word into the line FIFO. Define DROP_INVALID_EN to discard invalid lines in CALC.
module line_setup (
    input  logic         clk,
    input  logic         rst,
    line_setup_if.slave  bus,
    input  logic         frame_start,
    output logic [15:0]  line_count,
    output logic         busy
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] PUSH = 2'd2;

    typedef struct packed {
        logic [9:0]  x0;
        logic [9:0]  y0;
        logic [9:0]  x1;
        logic [9:0]  y1;
        logic [10:0] dy;
        logic [10:0] dx;
        logic [2:0]  color;
        logic        valid;
        logic [2:0]  octant;
    } line_word_t;

    logic [1:0]  state;
    logic [9:0]  x0_q, y0_q, x1_q, y1_q;
    logic [2:0]  color_q;
    logic        draw_q;
    logic [10:0] dx, dy, adx, ady;
    line_word_t  word;
    logic        capture;

    assign bus.in_ready   = (state == IDLE) & rst;
    assign bus.fifo_wr_en = (state == PUSH) & ~bus.fifo_full;
    assign busy           = (state != IDLE);
    assign capture        = bus.in_valid & bus.in_ready;

    // Operands are zero-extended to 11 bits, so |delta| <= 1023 and the magnitudes never overflow.
    always_comb begin
        dx  = {1'b0, x1_q} - {1'b0, x0_q};
        dy  = {1'b0, y1_q} - {1'b0, y0_q};
        adx = dx[10] ? (~dx + 11'd1) : dx;
        ady = dy[10] ? (~dy + 11'd1) : dy;
        word.x0     = x0_q;
        word.y0     = y0_q;
        word.x1     = x1_q;
        word.y1     = y1_q;
        word.dy     = dy;
        word.dx     = dx;
        word.color  = color_q;
        word.valid  = draw_q & (x0_q <= 10'd639) & (x1_q <= 10'd639)
                             & (y0_q <= 10'd479) & (y1_q <= 10'd479);
        word.octant = {ady > adx, dy[10], dx[10]};
    end

    always_ff @(posedge clk) begin
        if (capture) begin
            x0_q    <= bus.in_x0;
            y0_q    <= bus.in_y0;
            x1_q    <= bus.in_x1;
            y1_q    <= bus.in_y1;
            color_q <= bus.in_color;
            draw_q  <= bus.in_draw;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            bus.fifo_din <= '0;
        end else begin
            case (state)
                IDLE: if (capture) state <= CALC;
                CALC: begin
`ifdef DROP_INVALID_EN
                    if (!word.valid) begin
                        state <= IDLE;
                    end else begin
                        bus.fifo_din <= word;
                        state        <= PUSH;
                    end
`else
                    bus.fifo_din <= word;
                    state        <= PUSH;
`endif
                end
                PUSH: if (bus.fifo_wr_en) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // A write coinciding with frame_start counts as the first line of the new frame.
    always_ff @(posedge clk) begin
        if (!rst)
            line_count <= '0;
        else if (frame_start)
            line_count <= bus.fifo_wr_en ? 16'd1 : 16'd0;
        else if (bus.fifo_wr_en && line_count != 16'hFFFF)
            line_count <= line_count + 16'd1;
    end
endmodule

// File: tb/tb_line_setup.sv
// Self-checking bench for line_setup: directed and random segments against a behavioural model.
module tb_line_setup;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        frame_start = 1'b0;
    logic [15:0] line_count;
    logic        busy;
    int          vectors = 0;
    int          miscompares = 0;
    int          exp_count = 0;
    logic [68:0] last_din = '0;

    line_setup_if bus ();

    line_setup dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus.slave),
        .frame_start (frame_start),
        .line_count  (line_count),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [68:0] model(input logic [9:0] x0, y0, x1, y1,
                                          input logic [2:0] col, input logic draw);
        int dxi, dyi, adx, ady;
        logic [10:0] dx11, dy11;
        logic vld, steep;
        dxi  = int'(x1) - int'(x0);
        dyi  = int'(y1) - int'(y0);
        adx  = (dxi < 0) ? -dxi : dxi;
        ady  = (dyi < 0) ? -dyi : dyi;
        dx11 = dxi[10:0];
        dy11 = dyi[10:0];
        steep = (ady > adx);
        vld  = draw && x0 <= 639 && x1 <= 639 && y0 <= 479 && y1 <= 479;
        return {x0, y0, x1, y1, dy11, dx11, col, vld, steep, dyi < 0, dxi < 0};
    endfunction

    function automatic logic model_drop(input logic [68:0] w);
`ifdef DROP_INVALID_EN
        return !w[3];
`else
        return 1'b0;
`endif
    endfunction

    task automatic drive_garbage();
        bus.in_x0    = 10'($urandom);
        bus.in_y0    = 10'($urandom);
        bus.in_x1    = 10'($urandom);
        bus.in_y1    = 10'($urandom);
        bus.in_color = 3'($urandom);
        bus.in_draw  = 1'($urandom);
    endtask

    // One segment through the block, stalled by fifo_full for 'stall' cycles in PUSH.
    task automatic push_line(input logic [9:0] x0, y0, x1, y1, input logic [2:0] col,
                             input logic draw, input int stall, input logic fs,
                             output logic [68:0] got);
        logic [68:0] exp;
        logic drop;
        int n;
        exp  = model(x0, y0, x1, y1, col, draw);
        drop = model_drop(exp);
        got  = '0;
        @(negedge clk);
        bus.fifo_full = (stall > 0);
        bus.in_valid  = 1'b1;
        bus.in_x0 = x0; bus.in_y0 = y0; bus.in_x1 = x1; bus.in_y1 = y1;
        bus.in_color = col; bus.in_draw = draw;
        n = 0;
        while (!bus.in_ready && n < 20) begin @(negedge clk); n++; end
        vectors++;
        if (n >= 20) begin
            miscompares++;
            $display("FAIL in_ready_timeout: in_ready stayed %b, required 1", bus.in_ready);
            bus.in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        drive_garbage();
        vectors++;
        if ({busy, bus.in_ready, bus.fifo_wr_en} !== 3'b100) begin
            miscompares++;
            $display("FAIL calc_state: busy/in_ready/wr_en=%b required 100", {busy, bus.in_ready, bus.fifo_wr_en});
        end
        @(posedge clk);
        @(negedge clk);
        if (drop) begin
            bus.in_valid = 1'b0;
            bus.fifo_full = 1'b0;
            vectors++;
            if ({busy, bus.in_ready, bus.fifo_wr_en} !== 3'b010 || bus.fifo_din !== last_din || line_count !== 16'(exp_count)) begin
                miscompares++;
                $display("FAIL drop: busy/rdy/wr=%b din=%h cnt=%0d required 010 din=%h cnt=%0d",
                         {busy, bus.in_ready, bus.fifo_wr_en}, bus.fifo_din, line_count, last_din, exp_count);
            end
            got = bus.fifo_din;
            return;
        end
        for (int s = 0; s < stall; s++) begin
            vectors++;
            if (bus.fifo_wr_en !== 1'b0 || bus.fifo_din !== exp || bus.in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL stall%0d: wr_en=%b rdy=%b din=%h required wr_en=0 rdy=0 din=%h",
                         s, bus.fifo_wr_en, bus.in_ready, bus.fifo_din, exp);
            end
            @(posedge clk);
            @(negedge clk);
            drive_garbage();
        end
        bus.fifo_full = 1'b0;
        bus.in_valid  = 1'b0;
        frame_start   = fs;
        #1;
        vectors++;
        if (bus.fifo_wr_en !== 1'b1 || bus.fifo_din !== exp || bus.in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL write: wr_en=%b rdy=%b din=%h required wr_en=1 rdy=0 din=%h",
                     bus.fifo_wr_en, bus.in_ready, bus.fifo_din, exp);
        end
        got = bus.fifo_din;
        @(posedge clk);
        exp_count = fs ? 1 : ((exp_count == 65535) ? 65535 : exp_count + 1);
        last_din  = exp;
        @(negedge clk);
        frame_start = 1'b0;
        vectors++;
        if (line_count !== 16'(exp_count) || bus.in_ready !== 1'b1 || bus.fifo_wr_en !== 1'b0) begin
            miscompares++;
            $display("FAIL after_write: cnt=%0d rdy=%b wr_en=%b required cnt=%0d rdy=1 wr_en=0",
                     line_count, bus.in_ready, bus.fifo_wr_en, exp_count);
        end
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0; bus.fifo_full = 1'b0; drive_garbage();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({bus.in_ready, bus.fifo_wr_en, busy} !== 3'b000 || bus.fifo_din !== 69'd0 || line_count !== 16'd0) begin
            miscompares++;
            $display("FAIL reset: rdy/wr/busy=%b din=%h cnt=%0d required 000 din=0 cnt=0",
                     {bus.in_ready, bus.fifo_wr_en, busy}, bus.fifo_din, line_count);
        end
        rst = 1'b1;
    endtask

    task automatic test_shallow();
        logic [68:0] w;
        push_line(10, 20, 30, 25, 3'd5, 1'b1, 0, 1'b0, w);
        vectors++;
        if (w[17:7] !== 11'd20 || w[28:18] !== 11'd5 || w[2:0] !== 3'b000 || w[3] !== 1'b1 || w[6:4] !== 3'd5 || line_count !== 16'd1) begin
            miscompares++;
            $display("FAIL shallow: dx=%h dy=%h oct=%b v=%b col=%0d cnt=%0d required 014 005 000 1 5 1",
                     w[17:7], w[28:18], w[2:0], w[3], w[6:4], line_count);
        end
    endtask

    task automatic test_steep();
        logic [68:0] w;
        push_line(100, 100, 90, 50, 3'd2, 1'b1, 0, 1'b0, w);
        vectors++;
        if (w[17:7] !== 11'h7F6 || w[28:18] !== 11'h7CE || w[2:0] !== 3'b111) begin
            miscompares++;
            $display("FAIL steep_neg: dx=%h dy=%h oct=%b required 7f6 7ce 111", w[17:7], w[28:18], w[2:0]);
        end
        push_line(0, 0, 7, 7, 3'd1, 1'b1, 0, 1'b0, w);
        vectors++;
        if (w[2:0] !== 3'b000) begin
            miscompares++;
            $display("FAIL diagonal: oct=%b required 000", w[2:0]);
        end
        push_line(5, 9, 5, 9, 3'd7, 1'b1, 0, 1'b0, w);
        vectors++;
        if (w[28:7] !== 22'd0 || w[2:0] !== 3'b000 || w[3] !== 1'b1) begin
            miscompares++;
            $display("FAIL degenerate: dy_dx=%h oct=%b v=%b required 0 000 1", w[28:7], w[2:0], w[3]);
        end
    endtask

    task automatic test_invalid();
        logic [68:0] w;
        push_line(10, 10, 640, 20, 3'd3, 1'b1, 0, 1'b0, w);
        push_line(10, 10, 20, 20, 3'd3, 1'b0, 0, 1'b0, w);
        push_line(639, 479, 0, 0, 3'd4, 1'b1, 0, 1'b0, w);
        push_line(0, 480, 0, 0, 3'd4, 1'b1, 0, 1'b0, w);
    endtask

    task automatic test_backpressure();
        logic [68:0] w;
        push_line(200, 300, 50, 310, 3'd6, 1'b1, 5, 1'b0, w);
    endtask

    task automatic test_frame();
        logic [68:0] w;
        for (int i = 0; i < 3; i++) push_line(10'(i), 1, 20, 30, 3'd1, 1'b1, 0, 1'b0, w);
        @(negedge clk);
        frame_start = 1'b1;
        @(posedge clk);
        exp_count = 0;
        @(negedge clk);
        frame_start = 1'b0;
        vectors++;
        if (line_count !== 16'd0) begin
            miscompares++;
            $display("FAIL frame_clear: cnt=%0d required 0", line_count);
        end
        push_line(1, 2, 3, 4, 3'd2, 1'b1, 0, 1'b0, w);
        push_line(4, 3, 2, 1, 3'd2, 1'b1, 1, 1'b1, w);
    endtask

    task automatic test_random();
        logic [68:0] w;
        for (int i = 0; i < 40; i++) begin
            logic [9:0] x0, y0, x1, y1;
            x0 = 10'($urandom_range(0, 700));
            y0 = 10'($urandom_range(0, 540));
            x1 = ($urandom_range(0, 7) == 0) ? x0 : 10'($urandom_range(0, 700));
            y1 = ($urandom_range(0, 7) == 0) ? y0 : 10'($urandom_range(0, 540));
            if (i % 10 == 9) begin x0 = 10'($urandom); x1 = 10'($urandom); y0 = 10'($urandom); y1 = 10'($urandom); end
            push_line(x0, y0, x1, y1, 3'($urandom), ($urandom_range(0, 7) != 0),
                      $urandom_range(0, 3), 1'b0, w);
        end
    endtask

    task automatic test_saturate();
        logic [68:0] w;
        @(negedge clk);
        force dut.line_count = 16'hFFFD;
        #1;
        release dut.line_count;
        exp_count = 65533;
        for (int i = 0; i < 3; i++) push_line(10, 10, 12, 40, 3'd0, 1'b1, 0, 1'b0, w);
    endtask

    task automatic test_reset_mid_push();
        logic [68:0] w;
        @(negedge clk);
        bus.fifo_full = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_x0 = 30; bus.in_y0 = 40; bus.in_x1 = 60; bus.in_y1 = 45;
        bus.in_color = 3'd4; bus.in_draw = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        vectors++;
        if (busy !== 1'b1 || bus.fifo_wr_en !== 1'b0) begin
            miscompares++;
            $display("FAIL held_push: busy=%b wr_en=%b required 1 0", busy, bus.fifo_wr_en);
        end
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({busy, bus.in_ready, bus.fifo_wr_en} !== 3'b000 || bus.fifo_din !== 69'd0 || line_count !== 16'd0) begin
            miscompares++;
            $display("FAIL reset_mid_push: busy/rdy/wr=%b din=%h cnt=%0d required 000 0 0",
                     {busy, bus.in_ready, bus.fifo_wr_en}, bus.fifo_din, line_count);
        end
        rst = 1'b1;
        bus.fifo_full = 1'b0;
        exp_count = 0;
        last_din  = '0;
        #1;
        vectors++;
        if (bus.fifo_wr_en !== 1'b0 || bus.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL post_reset: wr_en=%b rdy=%b required 0 1", bus.fifo_wr_en, bus.in_ready);
        end
        push_line(100, 200, 300, 100, 3'd5, 1'b1, 0, 1'b0, w);
    endtask

    initial begin
        test_reset();
        test_shallow();
        test_steep();
        test_invalid();
        test_backpressure();
        test_frame();
        test_random();
        test_saturate();
        test_reset_mid_push();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
